// File: rtl/seq_mul37x22.sv
// seq_mul37x22: radix-2 shift-add unsigned multiplier with addend pass-through (option: SEQ_MUL_EARLY_TERM_EN)
module seq_mul37x22 #(
    parameter int A_WIDTH = 37,
    parameter int B_WIDTH = 22
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         in_a,
    input  logic [B_WIDTH-1:0]         in_b,
    input  logic [B_WIDTH-1:0]         in_addend,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] out_product,
    output logic [B_WIDTH-1:0]         out_addend,
    output logic                       busy
);
    localparam int P  = A_WIDTH + B_WIDTH;
    localparam int CW = $clog2(B_WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]         state, state_nxt;
    logic [P-1:0]       a_sh, acc;
    logic [B_WIDTH-1:0] b_sh, addend_q;
    logic [CW-1:0]      cnt;
    logic               accept, last;
    assign in_ready    = state == IDLE;
    assign out_valid   = state == DONE;
    assign busy        = state != IDLE;
    assign out_product = acc;
    assign out_addend  = addend_q;
    assign accept      = in_valid && in_ready;
`ifdef SEQ_MUL_EARLY_TERM_EN
    assign last = (cnt == CW'(B_WIDTH - 1)) || (b_sh[B_WIDTH-1:1] == '0);
`else
    assign last = cnt == CW'(B_WIDTH - 1);
`endif
    // next state: accept from IDLE, iterate in RUN, hold result in DONE until taken
    always_comb begin
        state_nxt = (state == IDLE) ? (in_valid ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) :
                    (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
    end
    // state register and shift-add datapath; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            addend_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh     <= {{B_WIDTH{1'b0}}, in_a};
                b_sh     <= in_b;
                acc      <= '0;
                cnt      <= '0;
                addend_q <= in_addend;
            end else if (state == RUN) begin
                acc  <= b_sh[0] ? acc + a_sh : acc;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_mul37x22.sv
// tb_seq_mul37x22: randomized self-checking bench for seq_mul37x22 against an arithmetic reference
module tb_seq_mul37x22;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [36:0] in_a = '0;
    logic [21:0] in_b = '0;
    logic [21:0] in_addend = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [58:0] out_product;
    logic [21:0] out_addend;
    logic        busy;
    int n_chk = 0;
    int n_fail = 0;

    seq_mul37x22 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_addend(in_addend), .out_valid(out_valid),
        .out_ready(out_ready), .out_product(out_product), .out_addend(out_addend), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [58:0] model_mul(input logic [36:0] a, input logic [21:0] b);
        logic [63:0] r;
        r = 64'(a) * 64'(b);
        return r[58:0];
    endfunction

    function automatic int model_lat(input logic [21:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
        if (b == 0) return 1;
        for (int i = 21; i >= 0; i--) if (b[i]) return i + 1;
        return 1;
`else
        return 22;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drives one operation; lat = edges from acceptance to out_valid, -1 if it never came
    task automatic run_op(input logic [36:0] a, input logic [21:0] b, input logic [21:0] ad_in,
                          output int lat, output logic [58:0] p, output logic [21:0] ad);
        int w;
        lat = -1;
        p = '0;
        ad = '0;
        w = 0;
        while (!in_ready && w < 50) begin step(); w++; end
        if (!in_ready) return;
        in_a = a; in_b = b; in_addend = ad_in; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (out_valid) begin lat = k; break; end
        end
        if (lat < 0) return;
        p = out_product;
        ad = out_addend;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
        n_chk++;
        if (out_product !== 59'd0 || out_addend !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_data: product=%h addend=%h, required 0 0", out_product, out_addend);
        end
    endtask

    task automatic test_vectors();
        logic [36:0] va [3] = '{37'h1F_FFFF_FFFF, 37'd5, 37'h1_0000_0001};
        logic [21:0] vb [3] = '{22'h3F_FFFF, 22'd3, 22'd0};
        logic [58:0] vp [3] = '{59'h7FF_FFDF_FFC0_0001, 59'd15, 59'd0};
        int lat;
        logic [58:0] p;
        logic [21:0] ad;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 22'h12345 + 22'(i), lat, p, ad);
            n_chk++;
            if (p !== vp[i]) begin
                n_fail++;
                $display("FAIL vec%0d_product: got %h, required %h", i, p, vp[i]);
            end
            n_chk++;
            if (ad !== 22'h12345 + 22'(i)) begin
                n_fail++;
                $display("FAIL vec%0d_addend: got %h, required %h", i, ad, 22'h12345 + 22'(i));
            end
            n_chk++;
            if (lat != model_lat(vb[i])) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d, required %0d", i, lat, model_lat(vb[i]));
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [58:0] p;
        logic [21:0] ad;
        logic [63:0] r;
        logic [36:0] a;
        logic [21:0] b, adi;
        for (int i = 0; i < 24; i++) begin
            r = {$urandom(), $urandom()};
            a = r[36:0];
            b = r[63:42] >> $urandom_range(0, 21);
            adi = 22'($urandom());
            run_op(a, b, adi, lat, p, ad);
            n_chk++;
            if (p !== model_mul(a, b) || ad !== adi || lat != model_lat(b)) begin
                n_fail++;
                $display("FAIL rand%0d: a=%h b=%h got product=%h addend=%h lat=%0d, required %h %h %0d",
                         i, a, b, p, ad, lat, model_mul(a, b), adi, model_lat(b));
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        logic [58:0] exp_p;
        exp_p = model_mul(37'h0_ABCD_1234, 22'h2A_5A5A);
        in_a = 37'h0_ABCD_1234; in_b = 22'h2A_5A5A; in_addend = 22'h0F0F0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin step(); k++; end
        n_chk++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL bp_wait: out_valid=%b, required 1", out_valid);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            in_a = 37'd11; in_b = 22'd13; in_addend = 22'h3;
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_product !== exp_p || out_addend !== 22'h0F0F0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b product=%h addend=%h, required 1 0 %h 0f0f0",
                         c, out_valid, in_ready, out_product, out_addend, exp_p);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
        step();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ignored_pulse: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, seen;
        logic [58:0] p;
        logic [21:0] ad;
        in_a = 37'h1_2345_6789; in_b = 22'h3F_FFFF; in_addend = 22'h1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_run: out_valid=%b busy=%b in_ready=%b, required 0 0 1", out_valid, busy, in_ready);
        end
        seen = 0;
        for (int c = 0; c < 25; c++) begin step(); if (out_valid) seen++; end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_stale: out_valid cycles=%0d, required 0", seen);
        end
        run_op(37'd7, 22'd9, 22'h2, lat, p, ad);
        n_chk++;
        if (p !== 59'd63 || lat != model_lat(22'd9)) begin
            n_fail++;
            $display("FAIL rst_next_op: product=%0d lat=%0d, required 63 %0d", p, lat, model_lat(22'd9));
        end
    endtask

    task automatic test_back_to_back();
        int acc_e [2];
        int hs_e [2];
        logic [58:0] res [2];
        int na, nh;
        na = 0; nh = 0;
        out_ready = 1'b1;
        in_a = 37'd3; in_b = 22'd4; in_addend = 22'h5; in_valid = 1'b1;
        for (int n = 0; n < 200 && nh < 2; n++) begin
            if (in_valid && in_ready && na < 2) begin acc_e[na] = n; na++; end
            if (out_valid && out_ready) begin hs_e[nh] = n; res[nh] = out_product; nh++; end
            step();
            if (na == 1) begin in_a = 37'd100; in_b = 22'd200; end
            if (na == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (nh != 2 || na != 2) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d handshakes=%0d, required 2 2", na, nh);
        end else begin
            n_chk++;
            if (res[0] !== 59'd12 || res[1] !== 59'd20000) begin
                n_fail++;
                $display("FAIL b2b_order: got %0d %0d, required 12 20000", res[0], res[1]);
            end
            n_chk++;
            if (acc_e[1] != hs_e[0] + 1) begin
                n_fail++;
                $display("FAIL b2b_reaccept: accept edge %0d, required %0d", acc_e[1], hs_e[0] + 1);
            end
            n_chk++;
            if (hs_e[0] - acc_e[0] != model_lat(22'd4) + 1) begin
                n_fail++;
                $display("FAIL b2b_latency: %0d edges, required %0d", hs_e[0] - acc_e[0], model_lat(22'd4) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
